add_sub_64bit_core: RTL and testbench
=====================================

// Module: add_sub_64bit_core
// PURPOSE
// - 64-bit two's-complement adder/subtractor with signed-overflow flag; ALU datapath block of the Y86 processor.
// - Operand mode selected per cycle by m (0 = add, 1 = subtract).
// - Result and flag are registered: one-cycle latency, single clock domain.
// PARAMETERS
// - WIDTH  64  operand/result width in bits; all behaviour below is stated for WIDTH = 64.
// PORTS
// - clk    in   1       rising-edge clock
// - rst_n  in   1       asynchronous, active-low reset
// - a      in   64      operand A, signed two's complement
// - b      in   64      operand B, signed two's complement
// - m      in   1       mode select: 0 = A+B, 1 = A-B
// - sum    out  64      registered result, signed
// - OF     out  1       registered signed-overflow flag
// BEHAVIOUR
// - Reset: rst_n low asynchronously forces sum = 0 and OF = 0, held while low; first update on the first rising clk after release.
// - Operation: bm = b XOR {64{m}}; carry_in = m; result = a + bm + carry_in, truncated to 64 bits (modulo 2^64 wrap).
// - Overflow: OF = (a[63] == bm[63]) && (result[63] != a[63]).
//   - Equivalently OF = c63 XOR c64, with c63 the carry into bit 63 and c64 the carry out of bit 63.
// - Carry out of bit 63 is not a port; it is discarded.
// - Latency: a, b and m sampled on rising clk N; sum and OF valid after clk N.
//   - Every cycle computes; there is no enable or handshake.
// - Boundaries:
//   - a = 2^63-1, b = 1, add gives sum = 0x8000_0000_0000_0000, OF = 1.
//   - a = -2^63, b = 1, subtract gives 0x7FFF_FFFF_FFFF_FFFF, OF = 1.
//   - a = 0, b = -2^63, subtract gives -2^63 with OF = 1 (negating the minimum value overflows).
//   - a = b with m = 1 gives 0 with OF = 0.
// - Reset asserted mid-stream: outputs clear immediately. The in-flight result is lost; no stale value appears after release.
// - Inputs with X/Z drive X to the outputs; no sanitising.
// STRUCTURE
// - Shared package (alu_pkg): localparam WIDTH = 64; MODE_ADD = 1'b0, MODE_SUB = 1'b1.
// - Sub-module full_adder (a, b, cin -> s, cout):
//   - 64 instances in a generate loop form the ripple-carry chain.
//   - carry[0] = m; OF taken from carry[63] ^ carry[64].
// - Top level: b-inversion XOR, ripple chain, then output register with asynchronous reset. No behavioural "+" in the datapath.
// TESTING (sample one cycle after applying stimulus; m = 0 unless stated)
// - Basic adds:
//   - a = 2811, b = 1012 -> sum = 3823, OF = 0.
//   - a = -1243, b = 1234 -> sum = -9, OF = 0.
//   - a = -7478, b = -46474 -> sum = -53952, OF = 0.
//   - a = 1092835, b = -1020 -> sum = 1091815, OF = 0.
// - Wide add: a = 7890678653, b = 4238598110567 -> sum = 4246488789220, OF = 0.
// - Positive overflow: a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 -> sum = 0x8000_0000_0000_0000, OF = 1.
// - Negative overflow: a = -9223372036854770000, b = -6000 -> sum = 9223372036854775616 (wrapped), OF = 1.
// - Subtract (m = 1):
//   - a = 5, b = 7 -> sum = -2, OF = 0.
//   - a = 0x8000_0000_0000_0000, b = 1 -> sum = 0x7FFF_FFFF_FFFF_FFFF, OF = 1.
//   - a = b = 12345 -> sum = 0, OF = 0.
// - Reset: drive rst_n low between clock edges while sum != 0.
//   - sum = 0 and OF = 0 before the next edge.
//   - After release, the first edge loads the current a, b, m.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the Y86 ALU add/subtract datapath
//
// Purpose:
//   Holds the datapath width and the encodings of the add/subtract mode
//   select. The adder top and anything driving its mode input use these
//   encodings.
//
// Contents:
//   WIDTH     operand/result width in bits
//   MODE_ADD  m value that selects A+B
//   MODE_SUB  m value that selects A-B

package alu_pkg;

  localparam int WIDTH = 64;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell for the ripple-carry chain
//
// Purpose:
//   Adds two bits and a carry-in. This is purely combinational and is
//   chained bit by bit by add_sub_64bit_core.
//
// Ports:
//   a     in   1   addend bit
//   b     in   1   addend bit (already inverted by the caller for subtract)
//   cin   in   1   carry into this bit position
//   s     out  1   sum bit
//   cout  out  1   carry out of this bit position

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // The propagate term is shared by the sum and the carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/add_sub_64bit_core.sv
// rtl/add_sub_64bit_core.sv - registered 64-bit two's-complement add/subtract with overflow
//
// Purpose:
//   This is the ALU add/subtract datapath for the Y86 core. On every rising
//   clk edge it samples a, b and m and registers either a+b (m=0) or a-b
//   (m=1), wrapped modulo 2^WIDTH, together with a signed-overflow flag.
//   The latency is one cycle. There is no enable and no handshake.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset; clears sum and OF
//   a      in   WIDTH  operand A, signed
//   b      in   WIDTH  operand B, signed
//   m      in   1      mode: MODE_ADD (0) = A+B, MODE_SUB (1) = A-B
//   sum    out  WIDTH  registered result
//   OF     out  1      registered signed-overflow flag

module add_sub_64bit_core
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] sum,
  output logic             OF
);

  logic [WIDTH-1:0] bm;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   carry;
  logic             of_next;

  // Subtraction is done as a + ~b + 1. The mode bit supplies both the
  // inversion mask and the +1 through the chain's carry-in.
  assign bm       = b ^ {WIDTH{m}};
  assign carry[0] = m;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder u_fa (
      .a    (a[i]),
      .b    (bm[i]),
      .cin  (carry[i]),
      .s    (result[i]),
      .cout (carry[i+1])
    );
  end

  // Signed overflow happens when the carry into the sign bit differs from
  // the carry out of it. The carry out itself (carry[WIDTH]) is not exported.
  assign of_next = carry[WIDTH-1] ^ carry[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      OF  <= 1'b0;
    end else begin
      sum <= result;
      OF  <= of_next;
    end
  end

endmodule : add_sub_64bit_core

// File: tb/tb_add_sub_64bit_core.sv
// tb/tb_add_sub_64bit_core.sv - scoreboard bench for add_sub_64bit_core

module tb_add_sub_64bit_core;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [63:0] sum;
    logic        of;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic        m;
  logic [63:0] sum;
  logic        OF;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  add_sub_64bit_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .m     (m),
    .sum   (sum),
    .OF    (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got_s, input logic got_o,
                       input logic [63:0] want_s, input logic want_o);
    checks++;
    if (got_s !== want_s) begin
      errors++;
      $display("FAIL %s sum: got %h want %h", name, got_s, want_s);
    end
    checks++;
    if (got_o !== want_o) begin
      errors++;
      $display("FAIL %s OF: got %b want %b", name, got_o, want_o);
    end
  endtask

  // Apply one vector at a negedge and queue its expected registered result.
  task automatic issue(input string name, input logic [63:0] va, input logic [63:0] vb,
                       input logic vm, input logic [63:0] es, input logic eo);
    exp_t e;
    @(negedge clk);
    a = va;
    b = vb;
    m = vm;
    e.name = name;
    e.sum  = es;
    e.of   = eo;
    exp_q.push_back(e);
  endtask

  // Monitor: every vector queued before an edge is due just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        check(e.name, sum, OF, e.sum, e.of);
      end
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    m = MODE_ADD;

    // Reset state while held low across edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset_init", sum, OF, 64'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("add_basic0", 64'sd2811,     64'sd1012,  MODE_ADD, 64'sd3823,    1'b0);
    issue("add_basic1", -64'sd1243,    64'sd1234,  MODE_ADD, -64'sd9,      1'b0);
    issue("add_basic2", -64'sd7478,    -64'sd46474, MODE_ADD, -64'sd53952, 1'b0);
    issue("add_basic3", 64'sd1092835,  -64'sd1020, MODE_ADD, 64'sd1091815, 1'b0);
    issue("add_wide",   64'sd7890678653, 64'sd4238598110567, MODE_ADD, 64'sd4246488789220, 1'b0);
    issue("add_pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, MODE_ADD, 64'h8000_0000_0000_0000, 1'b1);
    issue("add_neg_ovf", -64'sd9223372036854770000, -64'sd6000, MODE_ADD,
          64'd9223372036854775616, 1'b1);
    issue("sub_basic",  64'sd5,        64'sd7,     MODE_SUB, -64'sd2,      1'b0);
    issue("sub_min_ovf", 64'h8000_0000_0000_0000, 64'd1, MODE_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    issue("sub_equal",  64'sd12345,    64'sd12345, MODE_SUB, 64'd0,        1'b0);
    issue("sub_neg_min", 64'd0, 64'h8000_0000_0000_0000, MODE_SUB, 64'h8000_0000_0000_0000, 1'b1);
    issue("sub_to_min", 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, MODE_SUB,
          64'h8000_0000_0000_0000, 1'b0);
    issue("add_carry_out", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MODE_ADD,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    // Mid-stream reset between edges while sum is nonzero, with new inputs present.
    @(negedge clk);
    a = 64'd1;
    b = 64'd2;
    m = MODE_ADD;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", sum, OF, 64'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", sum, OF, 64'd0, 1'b0);

    // Release at a negedge and expect the very next edge to load current inputs.
    @(negedge clk);
    rst_n = 1'b1;
    a = 64'd100;
    b = 64'd58;
    m = MODE_SUB;
    exp_q.push_back('{name: "post_release", sum: 64'd42, of: 1'b0});

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_release: got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_add_sub_64bit_core
